// File: rtl/icache_ctrl.sv
// Direct-mapped instruction cache with a single-block fill controller.
// Hits are served combinationally as two sequential words per cycle. A miss
// freezes the pipeline and fetches one 256-bit block over iBlkRead.
//
// Block read handshake (iBlkRead / iBlk_ready): iBlkRead is the request
// valid. Once raised, it and iBlk_address are held constant until the cycle
// in which iBlk_ready is sampled high. That cycle is the transfer:
// block_read_fIM is captured on that edge, and iBlkRead drops on the same
// edge. iBlk_ready is meaningless while iBlkRead is low and is ignored then.
// A reset drops an outstanding request without any completion.
module icache_ctrl #(
  parameter int NUM_LINES = 16
) (
  input  logic         CLK,
  input  logic         RESET,
  input  logic [31:0]  Instr_address_2IM,
  input  logic         flush,
  output logic [31:0]  Instr1_fIM,
  output logic [31:0]  Instr2_fIM,
  output logic         single_fetch,
  output logic         FREEZE,
  output logic         iBlkRead,
  output logic [31:0]  iBlk_address,
  input  logic [255:0] block_read_fIM,
  input  logic         iBlk_ready,
  output logic         fsm_state
);

  localparam int IDX_W = (NUM_LINES > 1) ? $clog2(NUM_LINES) : 1;
  localparam int TAG_W = 27 - IDX_W;

  typedef enum logic {
    IDLE = 1'b0,
    FILL = 1'b1
  } state_t;

  state_t state, state_nxt;

  logic [NUM_LINES-1:0] valid;
  logic [TAG_W-1:0]     tag_mem  [NUM_LINES];
  logic [255:0]         data_mem [NUM_LINES];

  logic [2:0]       word_off;
  logic [2:0]       word_nxt;
  logic [IDX_W-1:0] idx;
  logic [TAG_W-1:0] tag;
  logic [IDX_W-1:0] miss_idx;
  logic [TAG_W-1:0] miss_tag;
  logic [255:0]     line;
  logic             hit;
  logic             fill_done;
  logic             unused_addr;

  // Address split and zero-latency lookup.
  assign word_off    = Instr_address_2IM[4:2];
  assign word_nxt    = word_off + 3'd1;
  assign idx         = Instr_address_2IM[4+IDX_W:5];
  assign tag         = Instr_address_2IM[31:5+IDX_W];
  assign line        = data_mem[idx];
  assign hit         = valid[idx] && (tag_mem[idx] == tag);
  assign fill_done   = (state == FILL) && iBlk_ready;
  assign fsm_state   = state;
  assign unused_addr = ^Instr_address_2IM[1:0];

  // Next state and combinational fetch outputs; NOPs and freeze by default.
  always_comb begin
    state_nxt    = state;
    Instr1_fIM   = 32'd0;
    Instr2_fIM   = 32'd0;
    single_fetch = 1'b1;
    FREEZE       = 1'b1;
    case (state)
      IDLE: begin
        if (hit) begin
          FREEZE     = 1'b0;
          Instr1_fIM = line[{word_off, 5'b0} +: 32];
          // The second word never crosses into the next line.
          if (word_off != 3'd7) begin
            Instr2_fIM   = line[{word_nxt, 5'b0} +: 32];
            single_fetch = 1'b0;
          end
        end else begin
          state_nxt = FILL;
        end
      end
      FILL: begin
        if (iBlk_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) state <= IDLE;
    else        state <= state_nxt;
  end

  // Block request and the latched miss line; held stable through FILL.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      iBlkRead     <= 1'b0;
      iBlk_address <= 32'd0;
      miss_idx     <= '0;
      miss_tag     <= '0;
    end else if (state == IDLE && !hit) begin
      iBlkRead     <= 1'b1;
      iBlk_address <= {Instr_address_2IM[31:5], 5'b0};
      miss_idx     <= idx;
      miss_tag     <= tag;
    end else if (fill_done) begin
      iBlkRead     <= 1'b0;
    end
  end

  // Valid bits: a flush clears everything, then a completing fill wins for its line.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      valid <= '0;
    end else begin
      if (flush)     valid <= '0;
      if (fill_done) valid[miss_idx] <= 1'b1;
    end
  end

  // Data and tag arrays, written only on fill completion; no reset needed.
  always_ff @(posedge CLK) begin
    if (fill_done) begin
      data_mem[miss_idx] <= block_read_fIM;
      tag_mem[miss_idx]  <= miss_tag;
    end
  end

endmodule
